llc_mesi_set_engine: RTL and testbench

//  Parametrised LLC tag/state engine: holds tag, MESI state and tree-PLRU bits per set, and processes one CPU or snoop

---
 rtl/llc_mesi_set_engine_if.sv | 33 +++
 rtl/llc_mesi_set_engine.sv | 258 +++++++++++++++++++++++++
 tb/tb_llc_mesi_set_engine.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/llc_mesi_set_engine_if.sv
// Command/response bundle between the command source and the LLC tag/state engine.
// The master modport drives commands and the slave modport (the engine) returns responses and counters.
interface llc_mesi_set_engine_if #(
    parameter int ADDR_SIZE = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic [3:0]           req_cmd;
    logic [ADDR_SIZE-1:0] req_addr;
    logic [1:0]           req_snoop;
    logic                 resp_valid;
    logic                 resp_hit;
    logic                 resp_bus_valid;
    logic [1:0]           resp_bus_op;
    logic                 resp_wb;
    logic [ADDR_SIZE-1:0] resp_wb_addr;
    logic [1:0]           resp_snoop;
    logic [2:0]           resp_l1_msg;
    logic [31:0]          cpu_hits;
    logic [31:0]          cpu_misses;

    modport master (
        output req_valid, req_cmd, req_addr, req_snoop,
        input  req_ready, resp_valid, resp_hit, resp_bus_valid, resp_bus_op, resp_wb,
               resp_wb_addr, resp_snoop, resp_l1_msg, cpu_hits, cpu_misses
    );

    modport slave (
        input  req_valid, req_cmd, req_addr, req_snoop,
        output req_ready, resp_valid, resp_hit, resp_bus_valid, resp_bus_op, resp_wb,
               resp_wb_addr, resp_snoop, resp_l1_msg, cpu_hits, cpu_misses
    );
endinterface

// File: rtl/llc_mesi_set_engine.sv
// LLC tag/MESI/tree-PLRU engine: one command at a time, response 3 cycles after accept (NUM_SETS+1 for CLEAR).
// Backpressure: req_ready only in IDLE, so at most one command per 4 cycles.
module llc_mesi_set_engine #(
    parameter int ADDR_SIZE  = 32,
    parameter int NUM_SETS   = 16,
    parameter int ASSOC      = 8,
    parameter int CACHE_LINE = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    llc_mesi_set_engine_if.slave bus
);
    localparam int BYTE_BITS  = $clog2(CACHE_LINE);
    localparam int INDEX_BITS = $clog2(NUM_SETS);
    localparam int TAG_BITS   = ADDR_SIZE - INDEX_BITS - BYTE_BITS;
    localparam int WAY_BITS   = $clog2(ASSOC);
    localparam int PLRU_BITS  = ASSOC - 1;

    localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3;
    localparam logic [3:0] CMD_DREAD = 4'd0, CMD_DWRITE = 4'd1, CMD_IREAD = 4'd2, CMD_SNP_INV = 4'd3,
                           CMD_SNP_RD = 4'd4, CMD_SNP_RWIM = 4'd6, CMD_CLEAR = 4'd8;
    localparam logic [1:0] SNP_NOHIT = 2'd0, SNP_HIT = 2'd1, SNP_HITM = 2'd2;
    localparam logic [1:0] BUS_READ = 2'd0, BUS_INVAL = 2'd2, BUS_RWIM = 2'd3;
    localparam logic [2:0] L1_NONE = 3'd0, L1_GET = 3'd1, L1_SEND = 3'd2, L1_INVAL = 3'd3, L1_EVICT = 3'd4;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_UPDATE, S_RESP, S_CLR} fsm_t;

    fsm_t                  fsm_q;
    logic [3:0]            cmd_q;
    logic [1:0]            snoop_q;
    logic [TAG_BITS-1:0]   req_tag_q;
    logic [INDEX_BITS-1:0] req_idx_q, clr_idx_q;

    logic [NUM_SETS-1:0][ASSOC-1:0][1:0]   st_q;
    logic [NUM_SETS-1:0][PLRU_BITS-1:0]    plru_q;
    logic [TAG_BITS-1:0]                   tag_q [NUM_SETS][ASSOC];
    logic [31:0]                           hits_q, misses_q;

    logic                hit_q;
    logic [WAY_BITS-1:0] hit_way_q, alloc_way_q;
    logic [1:0]          hit_st_q, vic_st_q;
    logic [TAG_BITS-1:0] vic_tag_q;

    logic                 resp_valid_q, resp_hit_q, resp_bus_valid_q, resp_wb_q;
    logic [1:0]           resp_bus_op_q, resp_snoop_q;
    logic [ADDR_SIZE-1:0] resp_wb_addr_q;
    logic [2:0]           resp_l1_q;

    // Lookup on the latched set: hit way, lowest invalid way, and PLRU victim.
    logic [ASSOC-1:0][1:0] row_st;
    logic [PLRU_BITS-1:0]  row_plru;
    logic                  hit_c, inv_found_c;
    logic [WAY_BITS-1:0]   hit_way_c, inv_way_c, alloc_way_c;

    assign row_st   = st_q[req_idx_q];
    assign row_plru = plru_q[req_idx_q];

    always_comb begin
        int                   node;
        logic [PLRU_BITS-1:0] psh;
        hit_c       = 1'b0;
        hit_way_c   = '0;
        inv_found_c = 1'b0;
        inv_way_c   = '0;
        for (int w = 0; w < ASSOC; w++) begin
            if (row_st[w] != ST_I && tag_q[req_idx_q][w] == req_tag_q) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_BITS'(w);
            end
        end
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (row_st[w] == ST_I) begin
                inv_found_c = 1'b1;
                inv_way_c   = WAY_BITS'(w);
            end
        end
        node = 0;
        for (int l = 0; l < WAY_BITS; l++) begin
            psh  = row_plru >> node;
            node = 2 * node + 1 + int'(psh[0]);
        end
        alloc_way_c = inv_found_c ? inv_way_c : WAY_BITS'(node - PLRU_BITS);
    end

    // Command decode from the registered lookup; stable from UPDATE through RESP.
    logic                 u_st_we, u_tag_we, u_plru_we, u_hit_inc, u_miss_inc;
    logic [WAY_BITS-1:0]  u_way;
    logic [1:0]           u_st;
    logic [PLRU_BITS-1:0] u_plru;
    logic                 n_hit, n_bus_valid, n_wb;
    logic [1:0]           n_bus_op, n_snoop;
    logic [ADDR_SIZE-1:0] n_wb_addr;
    logic [2:0]           n_l1;

    always_comb begin
        int                  node;
        logic [WAY_BITS-1:0] wsh;
        u_st_we = 1'b0; u_tag_we = 1'b0; u_plru_we = 1'b0; u_hit_inc = 1'b0; u_miss_inc = 1'b0;
        u_way = hit_way_q; u_st = hit_st_q;
        n_hit = 1'b0; n_bus_valid = 1'b0; n_bus_op = BUS_READ; n_wb = 1'b0; n_wb_addr = '0;
        n_snoop = SNP_NOHIT; n_l1 = L1_NONE;
        case (cmd_q)
            CMD_DREAD, CMD_IREAD, CMD_DWRITE: begin
                u_plru_we = 1'b1;
                if (hit_q) begin
                    n_hit     = 1'b1;
                    u_hit_inc = 1'b1;
                    n_l1      = L1_SEND;
                    if (cmd_q == CMD_DWRITE) begin
                        u_st_we = 1'b1;
                        u_st    = ST_M;
                        if (hit_st_q == ST_S) begin
                            n_bus_valid = 1'b1;
                            n_bus_op    = BUS_INVAL;
                        end
                    end
                end else begin
                    u_miss_inc  = 1'b1;
                    u_way       = alloc_way_q;
                    u_st_we     = 1'b1;
                    u_tag_we    = 1'b1;
                    n_bus_valid = 1'b1;
                    if (cmd_q == CMD_DWRITE) begin
                        n_bus_op = BUS_RWIM;
                        u_st     = ST_M;
                    end else begin
                        n_bus_op = BUS_READ;
                        u_st     = (snoop_q == SNP_HIT || snoop_q == SNP_HITM) ? ST_S : ST_E;
                    end
                    n_wb = (vic_st_q == ST_M);
                    if (n_wb) n_wb_addr = {vic_tag_q, req_idx_q, {BYTE_BITS{1'b0}}};
                    n_l1 = (vic_st_q != ST_I) ? L1_EVICT : L1_SEND;
                end
            end
            CMD_SNP_RD: begin
                if (hit_q) begin
                    u_st_we = 1'b1;
                    u_st    = ST_S;
                    n_snoop = (hit_st_q == ST_M) ? SNP_HITM : SNP_HIT;
                    if (hit_st_q == ST_M) n_l1 = L1_GET;
                end
            end
            CMD_SNP_RWIM: begin
                if (hit_q) begin
                    u_st_we = 1'b1;
                    u_st    = ST_I;
                    n_snoop = (hit_st_q == ST_M) ? SNP_HITM : SNP_HIT;
                    n_l1    = (hit_st_q == ST_M) ? L1_GET : L1_INVAL;
                end
            end
            CMD_SNP_INV: begin
                if (hit_q && hit_st_q == ST_S) begin
                    u_st_we = 1'b1;
                    u_st    = ST_I;
                    n_l1    = L1_INVAL;
                end
            end
            default: ;  // SNP_WR, PRINT, CLEAR and unused codes respond with all fields zero
        endcase

        // Point every node on the accessed way's path away from it.
        u_plru = row_plru;
        node   = 0;
        for (int l = 0; l < WAY_BITS; l++) begin
            wsh = u_way >> (WAY_BITS - 1 - l);
            if (wsh[0]) u_plru = u_plru & ~(PLRU_BITS'(1) << node);
            else        u_plru = u_plru |  (PLRU_BITS'(1) << node);
            node = 2 * node + 1 + int'(wsh[0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q     <= '0;
            plru_q   <= '0;
            hits_q   <= '0;
            misses_q <= '0;
        end else if (fsm_q == S_UPDATE) begin
            if (u_st_we)    st_q[req_idx_q][u_way] <= u_st;
            if (u_plru_we)  plru_q[req_idx_q]      <= u_plru;
            if (u_hit_inc)  hits_q                 <= hits_q + 32'd1;
            if (u_miss_inc) misses_q               <= misses_q + 32'd1;
        end else if (fsm_q == S_CLR) begin
            st_q[clr_idx_q]   <= '0;
            plru_q[clr_idx_q] <= '0;
            hits_q            <= '0;
            misses_q          <= '0;
        end
    end

    // Tags need no reset: a line is only matched while its state is not I.
    always_ff @(posedge clk) begin
        if (fsm_q == S_UPDATE && u_tag_we) tag_q[req_idx_q][u_way] <= req_tag_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q <= S_IDLE;
            cmd_q <= '0; snoop_q <= '0; req_tag_q <= '0; req_idx_q <= '0; clr_idx_q <= '0;
            hit_q <= 1'b0; hit_way_q <= '0; hit_st_q <= ST_I; alloc_way_q <= '0;
            vic_st_q <= ST_I; vic_tag_q <= '0;
            resp_valid_q <= 1'b0; resp_hit_q <= 1'b0; resp_bus_valid_q <= 1'b0; resp_bus_op_q <= '0;
            resp_wb_q <= 1'b0; resp_wb_addr_q <= '0; resp_snoop_q <= '0; resp_l1_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (fsm_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        cmd_q     <= bus.req_cmd;
                        snoop_q   <= bus.req_snoop;
                        req_tag_q <= bus.req_addr[ADDR_SIZE-1 -: TAG_BITS];
                        req_idx_q <= bus.req_addr[BYTE_BITS +: INDEX_BITS];
                        clr_idx_q <= '0;
                        fsm_q     <= (bus.req_cmd == CMD_CLEAR) ? S_CLR : S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    hit_q       <= hit_c;
                    hit_way_q   <= hit_way_c;
                    hit_st_q    <= row_st[hit_way_c];
                    alloc_way_q <= alloc_way_c;
                    vic_st_q    <= row_st[alloc_way_c];
                    vic_tag_q   <= tag_q[req_idx_q][alloc_way_c];
                    fsm_q       <= S_UPDATE;
                end
                S_UPDATE: fsm_q <= S_RESP;
                S_CLR: begin
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == INDEX_BITS'(NUM_SETS - 1)) fsm_q <= S_RESP;
                end
                S_RESP: begin
                    resp_valid_q     <= 1'b1;
                    resp_hit_q       <= n_hit;
                    resp_bus_valid_q <= n_bus_valid;
                    resp_bus_op_q    <= n_bus_op;
                    resp_wb_q        <= n_wb;
                    resp_wb_addr_q   <= n_wb_addr;
                    resp_snoop_q     <= n_snoop;
                    resp_l1_q        <= n_l1;
                    fsm_q            <= S_IDLE;
                end
                default: fsm_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready      = (fsm_q == S_IDLE);
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_hit       = resp_hit_q;
    assign bus.resp_bus_valid = resp_bus_valid_q;
    assign bus.resp_bus_op    = resp_bus_op_q;
    assign bus.resp_wb        = resp_wb_q;
    assign bus.resp_wb_addr   = resp_wb_addr_q;
    assign bus.resp_snoop     = resp_snoop_q;
    assign bus.resp_l1_msg    = resp_l1_q;
    assign bus.cpu_hits       = hits_q;
    assign bus.cpu_misses     = misses_q;
endmodule

// File: tb/tb_llc_mesi_set_engine.sv
// Directed bench for llc_mesi_set_engine with ASSOC=4, NUM_SETS=16, CACHE_LINE=64.
// Address = {tag, set[3:0], offset[5:0]}, so a line address is tag<<10 | set<<6.
module tb_llc_mesi_set_engine;
    localparam logic [3:0] DREAD = 4'd0, DWRITE = 4'd1, SNP_INV = 4'd3, SNP_RD = 4'd4,
                           SNP_WR = 4'd5, SNP_RWIM = 4'd6, CLEAR = 4'd8, PRINT = 4'd9, UNDEF = 4'd7;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   lat;

    always #5 clk = ~clk;

    llc_mesi_set_engine_if #(.ADDR_SIZE(32)) bus ();

    llc_mesi_set_engine #(.ADDR_SIZE(32), .NUM_SETS(16), .ASSOC(4), .CACHE_LINE(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int tag, input int set);
        return (32'(tag) << 10) | (32'(set) << 6);
    endfunction

    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [1:0] s);
        int k;
        logic got;
        k = 0;
        while (!bus.req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_cmd   = c;
        bus.req_addr  = a;
        bus.req_snoop = s;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        k   = 0;
        got = 1'b0;
        while (!got && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (bus.resp_valid) got = 1'b1;
        end
        lat = got ? k : 0;
        chk("resp_seen", bus.resp_valid, 1);
    endtask

    initial begin
        logic saw;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_cmd   = '0;
        bus.req_addr  = '0;
        bus.req_snoop = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_l1_msg", bus.resp_l1_msg, 0);
        chk("rst_bus_valid", bus.resp_bus_valid, 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_hits", bus.cpu_hits, 0);
        chk("rst_misses", bus.cpu_misses, 0);

        // Fill all four ways of set 3 with E lines
        for (int t = 1; t <= 4; t++) begin
            issue(DREAD, mk(t, 3), 2'd0);
            chk("fill_hit", bus.resp_hit, 0);
            chk("fill_bus_valid", bus.resp_bus_valid, 1);
            chk("fill_bus_op", bus.resp_bus_op, 0);
            chk("fill_l1", bus.resp_l1_msg, 2);
            chk("fill_wb", bus.resp_wb, 0);
            if (t == 1) begin
                chk("latency", lat, 3);
                @(posedge clk);
                #1 chk("resp_one_cycle", bus.resp_valid, 0);
            end
        end
        chk("misses_after_fill", bus.cpu_misses, 4);

        // Set full, PLRU 000: victim is way 0 (tag 1); then PLRU points at way 2 (tag 3)
        issue(DREAD, mk(5, 3), 2'd0);
        chk("evict1_l1", bus.resp_l1_msg, 4);
        chk("evict1_wb", bus.resp_wb, 0);
        issue(DREAD, mk(1, 3), 2'd0);
        chk("tag1_gone_hit", bus.resp_hit, 0);
        chk("tag1_gone_l1", bus.resp_l1_msg, 4);

        // Ways now {5,2,1,4}; write tag 2 (E, way1) with a nonzero offset
        issue(DWRITE, mk(2, 3) | 32'h14, 2'd0);
        chk("wr_e_hit", bus.resp_hit, 1);
        chk("wr_e_bus_valid", bus.resp_bus_valid, 0);
        // Victims in order: way3, way0, way2, then the M line in way1
        issue(DREAD, mk(6, 3), 2'd0);
        chk("evict_w3_wb", bus.resp_wb, 0);
        chk("evict_w3_l1", bus.resp_l1_msg, 4);
        issue(DREAD, mk(7, 3), 2'd0);
        chk("evict_w0_wb", bus.resp_wb, 0);
        issue(DREAD, mk(8, 3), 2'd0);
        chk("evict_w2_wb", bus.resp_wb, 0);
        issue(DREAD, mk(9, 3), 2'd0);
        chk("evict_m_wb", bus.resp_wb, 1);
        chk("evict_m_wb_addr", bus.resp_wb_addr, 32'h0000_08C0);
        chk("evict_m_l1", bus.resp_l1_msg, 4);
        chk("evict_m_bus_op", bus.resp_bus_op, 0);
        chk("hits_set3", bus.cpu_hits, 1);
        chk("misses_set3", bus.cpu_misses, 10);

        // Shared fill, upgrade, snoops on set 5
        issue(DREAD, mk(16, 5), 2'd1);
        chk("shared_fill_hit", bus.resp_hit, 0);
        chk("shared_fill_op", bus.resp_bus_op, 0);
        issue(DWRITE, mk(16, 5), 2'd0);
        chk("upgrade_hit", bus.resp_hit, 1);
        chk("upgrade_bus_valid", bus.resp_bus_valid, 1);
        chk("upgrade_bus_op", bus.resp_bus_op, 2);
        issue(SNP_WR, mk(16, 5), 2'd0);
        chk("snp_wr_lat", lat, 3);
        chk("snp_wr_hit", bus.resp_hit, 0);
        chk("snp_wr_bus_valid", bus.resp_bus_valid, 0);
        chk("snp_wr_snoop", bus.resp_snoop, 0);
        issue(SNP_RD, mk(16, 5), 2'd0);
        chk("snp_rd_m_snoop", bus.resp_snoop, 2);
        chk("snp_rd_m_l1", bus.resp_l1_msg, 1);
        chk("snp_rd_m_bus_valid", bus.resp_bus_valid, 0);
        issue(SNP_RD, mk(16, 5), 2'd0);
        chk("snp_rd_s_snoop", bus.resp_snoop, 1);
        chk("snp_rd_s_l1", bus.resp_l1_msg, 0);
        issue(SNP_RWIM, mk(16, 5), 2'd0);
        chk("snp_rwim_snoop", bus.resp_snoop, 1);
        chk("snp_rwim_l1", bus.resp_l1_msg, 3);
        issue(DREAD, mk(16, 5), 2'd0);
        chk("reread_hit", bus.resp_hit, 0);
        chk("reread_bus_valid", bus.resp_bus_valid, 1);
        chk("reread_bus_op", bus.resp_bus_op, 0);
        chk("reread_l1", bus.resp_l1_msg, 2);
        issue(SNP_INV, mk(16, 5), 2'd0);
        chk("snp_inv_e_snoop", bus.resp_snoop, 0);
        chk("snp_inv_e_l1", bus.resp_l1_msg, 0);
        issue(SNP_RD, mk(16, 5), 2'd0);
        chk("e_kept_snoop", bus.resp_snoop, 1);
        issue(SNP_INV, mk(16, 5), 2'd0);
        chk("snp_inv_s_l1", bus.resp_l1_msg, 3);
        chk("snp_inv_s_snoop", bus.resp_snoop, 0);
        issue(SNP_RD, mk(16, 5), 2'd0);
        chk("s_gone_snoop", bus.resp_snoop, 0);
        issue(PRINT, mk(9, 3), 2'd0);
        chk("print_l1", bus.resp_l1_msg, 0);
        chk("print_hit", bus.resp_hit, 0);
        issue(UNDEF, mk(9, 3), 2'd0);
        chk("undef_bus_valid", bus.resp_bus_valid, 0);
        chk("hits_before_clear", bus.cpu_hits, 2);
        chk("misses_before_clear", bus.cpu_misses, 12);

        issue(CLEAR, 32'd0, 2'd0);
        chk("clear_latency", lat, 17);
        chk("clear_hits", bus.cpu_hits, 0);
        chk("clear_misses", bus.cpu_misses, 0);
        issue(DREAD, mk(9, 3), 2'd0);
        chk("after_clear_hit", bus.resp_hit, 0);
        chk("after_clear_misses", bus.cpu_misses, 1);

        // Reset during UPDATE of a write miss
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_cmd   = DWRITE;
        bus.req_addr  = mk(51, 7);
        bus.req_snoop = 2'd0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        saw = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1 saw = saw | bus.resp_valid;
        end
        @(negedge clk) rst = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1 saw = saw | bus.resp_valid;
        end
        chk("abort_no_resp", saw, 0);
        chk("abort_ready", bus.req_ready, 1);
        issue(DREAD, mk(51, 7), 2'd0);
        chk("abort_line_invalid", bus.resp_hit, 0);
        chk("abort_misses", bus.cpu_misses, 1);
        chk("abort_l1", bus.resp_l1_msg, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
